// File: rtl/fw_dnn_capture.sv
`default_nettype none
// ============================================================================
// Module      : fw_dnn_capture
// Description : Captures {fw_dnn_output_1, fw_dnn_output_0} at a programmable
//               delay after each fw_bxclk rising edge. Sixteen 2-bit samples
//               are packed into each 32-bit word of the capture buffer.
//               Optional macro FW_DNN_CAPTURE_EVENT_TRIG_EN holds ARM until
//               fw_dn_event_toggle changes.
// Revision    : 1.0 - initial release
// ============================================================================
module fw_dnn_capture #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          fw_pl_clk1,
    input  logic          fw_rst_n,
    input  logic          fw_bxclk,
    input  logic          fw_dnn_output_0,
    input  logic          fw_dnn_output_1,
    input  logic          fw_dn_event_toggle,
    input  logic          cap_start,
    input  logic          cap_abort,
    input  logic [AW:0]   cap_num_words,
    input  logic [4:0]    cap_sample_dly,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          cap_busy,
    output logic          cap_done,
    output logic          cap_miss,
    output logic [AW:0]   cap_wr_cnt
);

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_ARM     = 2'd1;
    localparam logic [1:0]  c_ST_CAPTURE = 2'd2;
    localparam logic [1:0]  c_ST_DONE    = 2'd3;
    localparam logic [AW:0] c_DEPTH_W    = (AW+1)'(DEPTH);

    logic [1:0]    r_state;
    logic          r_bx_q;
    logic [4:0]    r_dly_cnt;
    logic          r_pend;
    logic [3:0]    r_idx;
    logic [31:0]   r_shift;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_wr_cnt;
    logic [AW:0]   r_num_eff;
    logic          r_miss;
    logic [31:0]   r_mem [DEPTH];

    logic          w_bx_edge;
    logic          w_capture;
    logic          w_sample;
    logic          w_wr;
    logic          w_arm_entry;
    logic          w_trig;
    logic [1:0]    w_sample_bits;
    logic [AW:0]   w_num_eff;
    logic [AW:0]   w_wr_cnt_nxt;

    assign w_bx_edge     = fw_bxclk & ~r_bx_q;
    assign w_capture     = (r_state == c_ST_CAPTURE);
    assign w_arm_entry   = ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE)) && cap_start;
    assign w_sample_bits = {fw_dnn_output_1, fw_dnn_output_0};
    assign w_num_eff     = (cap_num_words > c_DEPTH_W) ? c_DEPTH_W : cap_num_words;
    assign w_wr_cnt_nxt  = r_wr_cnt + {{AW{1'b0}}, 1'b1};

    // A fresh edge always overrides whatever sample was pending; a zero delay
    // samples in the edge cycle itself.
    assign w_sample = w_capture && !cap_abort &&
                      (w_bx_edge ? (cap_sample_dly == 5'd0)
                                 : (r_pend && (r_dly_cnt == 5'd0)));
    assign w_wr     = w_capture && !cap_abort && r_wr_en;

`ifdef FW_DNN_CAPTURE_EVENT_TRIG_EN
    logic r_evt_ref;

    always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            r_evt_ref <= 1'b0;
        end else if (w_arm_entry) begin
            r_evt_ref <= fw_dn_event_toggle;
        end
    end

    assign w_trig = (fw_dn_event_toggle != r_evt_ref);
`else
    logic w_unused_evt;
    assign w_unused_evt = fw_dn_event_toggle;
    assign w_trig       = 1'b1;
`endif

    always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            r_state   <= c_ST_IDLE;
            r_bx_q    <= 1'b0;
            r_dly_cnt <= 5'd0;
            r_pend    <= 1'b0;
            r_idx     <= 4'd0;
            r_shift   <= 32'd0;
            r_wr_en   <= 1'b0;
            r_wr_ptr  <= '0;
            r_wr_cnt  <= '0;
            r_num_eff <= '0;
            r_miss    <= 1'b0;
        end else begin
            r_bx_q <= fw_bxclk;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (cap_start) begin
                        r_state   <= c_ST_ARM;
                        r_wr_ptr  <= '0;
                        r_wr_cnt  <= '0;
                        r_idx     <= 4'd0;
                        r_miss    <= 1'b0;
                        r_pend    <= 1'b0;
                        r_dly_cnt <= 5'd0;
                        r_shift   <= 32'd0;
                        r_wr_en   <= 1'b0;
                        r_num_eff <= w_num_eff;
                    end
                end
                c_ST_ARM: begin
                    if (cap_abort) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_num_eff == '0) begin
                        r_state <= c_ST_DONE;
                    end else if (w_trig) begin
                        r_state <= c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    if (cap_abort) begin
                        r_state <= c_ST_IDLE;
                        r_pend  <= 1'b0;
                        r_wr_en <= 1'b0;
                        r_idx   <= 4'd0;
                        r_shift <= 32'd0;
                    end else begin
                        if (w_bx_edge) begin
                            if (r_pend) begin
                                r_miss <= 1'b1;
                            end
                            if (cap_sample_dly == 5'd0) begin
                                r_pend <= 1'b0;
                            end else begin
                                r_pend    <= 1'b1;
                                r_dly_cnt <= cap_sample_dly - 5'd1;
                            end
                        end else if (r_pend) begin
                            if (r_dly_cnt == 5'd0) begin
                                r_pend <= 1'b0;
                            end else begin
                                r_dly_cnt <= r_dly_cnt - 5'd1;
                            end
                        end
                        if (w_wr) begin
                            r_wr_en  <= 1'b0;
                            r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
                            r_wr_cnt <= w_wr_cnt_nxt;
                            if (w_wr_cnt_nxt == r_num_eff) begin
                                r_state <= c_ST_DONE;
                            end
                        end
                        // The completed word is written from r_shift next cycle;
                        // a sample in that same cycle only updates it afterwards.
                        if (w_sample) begin
                            r_shift[{r_idx, 1'b0} +: 2] <= w_sample_bits;
                            r_idx <= r_idx + 4'd1;
                            if (r_idx == 4'hF) begin
                                r_wr_en <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge fw_pl_clk1) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            rd_data <= 32'd0;
        end else begin
            rd_data <= r_mem[rd_addr];
        end
    end

    assign cap_busy   = (r_state == c_ST_ARM) || (r_state == c_ST_CAPTURE);
    assign cap_done   = (r_state == c_ST_DONE);
    assign cap_miss   = r_miss;
    assign cap_wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fw_dnn_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_fw_dnn_capture
// Description : Scoreboard bench for fw_dnn_capture with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fw_dnn_capture;

    localparam int DEPTH     = 64;
    localparam int AW        = 6;
    localparam int BX_PERIOD = 10;

    logic          fw_pl_clk1;
    logic          fw_rst_n;
    logic          fw_bxclk;
    logic          fw_dnn_output_0;
    logic          fw_dnn_output_1;
    logic          fw_dn_event_toggle;
    logic          cap_start;
    logic          cap_abort;
    logic [AW:0]   cap_num_words;
    logic [4:0]    cap_sample_dly;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          cap_busy;
    logic          cap_done;
    logic          cap_miss;
    logic [AW:0]   cap_wr_cnt;

    logic [1:0] dnn_static;
    logic [1:0] dnn_pat;
    logic [3:0] rise_cnt;
    bit         pat_mode;
    bit         bx_run;
    int         bx_ph;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t rd_q[$];
    exp_t st_q[$];
    bit   rd_en;
    bit   rd_en_d;
    bit   st_req;
    int   checks;
    int   errors;

    assign {fw_dnn_output_1, fw_dnn_output_0} = pat_mode ? dnn_pat : dnn_static;

    fw_dnn_capture #(.DEPTH(DEPTH), .AW(AW)) u_dut (
        .fw_pl_clk1         (fw_pl_clk1),
        .fw_rst_n           (fw_rst_n),
        .fw_bxclk           (fw_bxclk),
        .fw_dnn_output_0    (fw_dnn_output_0),
        .fw_dnn_output_1    (fw_dnn_output_1),
        .fw_dn_event_toggle (fw_dn_event_toggle),
        .cap_start          (cap_start),
        .cap_abort          (cap_abort),
        .cap_num_words      (cap_num_words),
        .cap_sample_dly     (cap_sample_dly),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .cap_busy           (cap_busy),
        .cap_done           (cap_done),
        .cap_miss           (cap_miss),
        .cap_wr_cnt         (cap_wr_cnt)
    );

    initial begin
        fw_pl_clk1 = 1'b0;
        forever #5 fw_pl_clk1 = ~fw_pl_clk1;
    end

    // Bunch-crossing clock, 5 high / 5 low; in pattern mode the DNN bits step
    // through 0,1,2,3 on successive rising edges.
    initial begin
        fw_bxclk = 1'b0;
        dnn_pat  = 2'b00;
        rise_cnt = 4'd0;
        bx_ph    = 0;
        forever begin
            @(posedge fw_pl_clk1);
            #1;
            if (bx_run) begin
                fw_bxclk = (bx_ph < BX_PERIOD / 2);
                if (bx_ph == 0) begin
                    dnn_pat  = rise_cnt[1:0];
                    rise_cnt = rise_cnt + 4'd1;
                end
                bx_ph = (bx_ph == BX_PERIOD - 1) ? 0 : bx_ph + 1;
            end else begin
                fw_bxclk = 1'b0;
                bx_ph    = 0;
                rise_cnt = 4'd0;
            end
        end
    end

    function automatic logic [31:0] pack_st(input logic b, input logic d,
                                            input logic m, input logic [AW:0] c);
        return {20'd0, b, d, m, 2'b00, c};
    endfunction

    always @(posedge fw_pl_clk1) rd_en_d <= rd_en;

    always @(negedge fw_pl_clk1) begin
        exp_t        e;
        logic [31:0] act;
        if (rd_en_d) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h required nothing", rd_data);
            end else begin
                e = rd_q.pop_front();
                if (rd_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h required %h", e.name, rd_data, e.exp);
                end
            end
        end
        if (st_req) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL st_unexpected: status request with empty queue");
            end else begin
                e   = st_q.pop_front();
                act = (e.kind == 1) ? rd_data
                                    : pack_st(cap_busy, cap_done, cap_miss, cap_wr_cnt);
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h required %h (busy,done,miss,cnt packed)",
                             e.name, act, e.exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge fw_pl_clk1);
            #1;
        end
    endtask

    task automatic set_bx(input bit on, input bit pat);
        @(negedge fw_pl_clk1);
        bx_run   = on;
        pat_mode = pat;
    endtask

    task automatic exp_st(input string nm, input logic b, input logic d,
                          input logic m, input int c);
        st_q.push_back('{nm, 0, pack_st(b, d, m, 7'(c))});
        st_req = 1'b1;
        @(negedge fw_pl_clk1);
        #1;
        st_req = 1'b0;
    endtask

    task automatic exp_rd_now(input string nm, input logic [31:0] v);
        st_q.push_back('{nm, 1, v});
        st_req = 1'b1;
        @(negedge fw_pl_clk1);
        #1;
        st_req = 1'b0;
    endtask

    task automatic rd(input string nm, input int addr, input logic [31:0] v);
        rd_addr = 6'(addr);
        rd_en   = 1'b1;
        rd_q.push_back('{nm, 0, v});
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic pulse(input bit s, input bit a);
        cap_start = s;
        cap_abort = a;
        cyc(1);
        cap_start = 1'b0;
        cap_abort = 1'b0;
    endtask

    task automatic setup(input int nw, input int dly, input logic [1:0] dnn);
        cap_num_words  = 7'(nw);
        cap_sample_dly = 5'(dly);
        dnn_static     = dnn;
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max && !cap_done; i++) cyc(1);
    endtask

    task automatic wait_cnt(input int n, input int max);
        for (int i = 0; i < max && int'(cap_wr_cnt) < n; i++) cyc(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1);
    end

    initial begin
        checks             = 0;
        errors             = 0;
        fw_rst_n           = 1'b0;
        fw_dn_event_toggle = 1'b0;
        cap_start          = 1'b0;
        cap_abort          = 1'b0;
        rd_addr            = '0;
        rd_en              = 1'b0;
        st_req             = 1'b0;
        bx_run             = 1'b0;
        pat_mode           = 1'b0;
        setup(0, 0, 2'b00);
        cyc(3);
        exp_st("reset_status", 0, 0, 0, 0);
        exp_rd_now("reset_rd_data", 32'h0);
        cyc(1);
        fw_rst_n = 1'b1;
        cyc(2);

        // Basic capture: constant 2'b10 gives alternating bit pattern
        set_bx(1, 0);
        setup(2, 2, 2'b10);
        cyc(1);
        pulse(1, 0);
        wait_done(1000);
        exp_st("basic_done", 0, 1, 0, 2);
        rd("basic_word0", 0, 32'hAAAA_AAAA);
        rd("basic_word1", 1, 32'hAAAA_AAAA);

        // Packing order with zero delay: samples 0,1,2,3 repeat -> 0xE4 per byte
        set_bx(0, 0);
        cyc(3);
        setup(1, 0, 2'b00);
        pulse(1, 0);
        cyc(1);
        set_bx(1, 1);
        wait_done(400);
        exp_st("pack_done", 0, 1, 0, 1);
        rd("pack_word0", 0, 32'hE4E4_E4E4);
        rd("pack_word1_kept", 1, 32'hAAAA_AAAA);

        // Delay longer than the bx period: every edge drops the pending sample
        set_bx(1, 0);
        setup(2, 15, 2'b01);
        cyc(1);
        pulse(1, 0);
        exp_st("arm_clears", 1, 0, 0, 0);
        cyc(60);
        exp_st("miss_sticky", 1, 0, 1, 0);
        pulse(0, 1);
        exp_st("abort_idle", 0, 0, 1, 0);

        // Start ignored mid-capture; start+abort together aborts
        setup(3, 2, 2'b01);
        cyc(1);
        pulse(1, 0);
        wait_cnt(1, 400);
        pulse(1, 0);
        exp_st("start_ignored", 1, 0, 0, 1);
        pulse(1, 1);
        exp_st("start_abort_idle", 0, 0, 0, 1);
        rd("abort_word0", 0, 32'h5555_5555);
        rd("abort_partial_dropped", 1, 32'hAAAA_AAAA);

        // Zero-word capture completes two cycles after start
        setup(0, 2, 2'b11);
        cyc(1);
        pulse(1, 0);
        exp_st("nw0_arm", 1, 0, 0, 0);
        cyc(1);
        exp_st("nw0_done", 0, 1, 0, 0);

        // Oversized request clamps to DEPTH words
        setup(DEPTH + 1, 2, 2'b11);
        cyc(1);
        pulse(1, 0);
        wait_done(12000);
        exp_st("clamp_done", 0, 1, 0, DEPTH);
        rd("clamp_first", 0, 32'hFFFF_FFFF);
        rd("clamp_last", DEPTH - 1, 32'hFFFF_FFFF);

        // Reset in the middle of word 1 of 3
        setup(3, 2, 2'b10);
        cyc(1);
        pulse(1, 0);
        wait_cnt(1, 400);
        cyc(50);
        fw_rst_n = 1'b0;
        exp_st("midreset_status", 0, 0, 0, 0);
        exp_rd_now("midreset_rd_data", 32'h0);
        cyc(2);
        fw_rst_n = 1'b1;
        cyc(30);
        exp_st("postreset_idle", 0, 0, 0, 0);
        rd("postreset_word0", 0, 32'hAAAA_AAAA);
        rd("postreset_word1", 1, 32'hFFFF_FFFF);

`ifdef FW_DNN_CAPTURE_EVENT_TRIG_EN
        // ARM holds until the event toggle changes
        setup(1, 2, 2'b01);
        cyc(1);
        pulse(1, 0);
        cyc(300);
        exp_st("trig_wait", 1, 0, 0, 0);
        fw_dn_event_toggle = ~fw_dn_event_toggle;
        wait_done(400);
        exp_st("trig_done", 0, 1, 0, 1);
        rd("trig_word0", 0, 32'h5555_5555);
`endif

        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
